// File: rtl/gearbox_32_66.sv
// gearbox_32_66: packs 32-bit serial-side words into 66-bit blocks and hunts for
// 64b/66b block lock by slipping one bit per bad sync header while unlocked.
module gearbox_32_66 #(
  parameter int LOCK_GOOD = 64,
  parameter int WINDOW    = 64,
  parameter int SLIP_BAD  = 16
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [65:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        locked
);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(SLIP_BAD + 1);
  localparam logic [GW-1:0] G_MAX = GW'(LOCK_GOOD);
  localparam logic [WW-1:0] W_MAX = WW'(WINDOW);
  localparam logic [BW-1:0] B_MAX = BW'(SLIP_BAD);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t          state_q, state_d;
  logic [96:0]     buf_q, buf_d, ins;
  logic [6:0]      fill_q, fill_d, shift, pos;
  logic            slip_q, slip_d;
  logic [GW-1:0]   good_q, good_d;
  logic [WW-1:0]   win_q, win_d;
  logic [BW-1:0]   bad_q, bad_d;
  logic            push, pop, slip, hdr_good;
  assign dout       = buf_q[65:0];
  assign dout_valid = (fill_q >= 7'd66) && !slip_q;
  assign din_ready  = !arst && ((fill_q < 7'd66) || (dout_valid && dout_ready));
  assign locked     = (state_q == LOCKED);
  assign push       = din_valid && din_ready;
  assign pop        = dout_valid && dout_ready;
  assign slip       = slip_q && (fill_q != 7'd0);
  assign hdr_good   = buf_q[0] ^ buf_q[1];
  // Bits above fill are kept zero, so a new word can simply be OR'ed in.
  always_comb begin
    shift  = pop ? 7'd66 : {6'b0, slip};
    pos    = fill_q - shift;
    ins    = {65'b0, din} << pos;
    buf_d  = (buf_q >> shift) | (push ? ins : 97'b0);
    fill_d = fill_q - shift + (push ? 7'd32 : 7'd0);
  end
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    bad_d   = bad_q;
    slip_d  = slip_q && !slip;
    if (pop && state_q == UNLOCKED) begin
      good_d = hdr_good ? ((good_q == G_MAX) ? good_q : good_q + 1'b1) : '0;
      slip_d = !hdr_good;
      if (hdr_good && good_d == G_MAX) begin
        state_d = LOCKED;
        win_d   = '0;
        bad_d   = '0;
      end
    end else if (pop) begin
      win_d = (win_q == W_MAX) ? win_q : win_q + 1'b1;
      bad_d = (hdr_good || bad_q == B_MAX) ? bad_q : bad_q + 1'b1;
      if (bad_d == B_MAX) begin
        state_d = UNLOCKED;
        good_d  = '0;
        slip_d  = 1'b1;
      end else if (win_d == W_MAX) begin
        win_d = '0;
        bad_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= UNLOCKED;
      buf_q   <= '0;
      fill_q  <= '0;
      slip_q  <= 1'b0;
      good_q  <= '0;
      win_q   <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      slip_q  <= slip_d;
      good_q  <= good_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
    end
  end
endmodule

// File: tb/tb_gearbox_32_66.sv
// tb_gearbox_32_66: random and directed streams checked against a bit-queue model
// of the received stream with the sync-header lock rules applied per block.
module tb_gearbox_32_66;
  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [65:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        locked;

  gearbox_32_66 dut (
    .clk(clk), .arst(arst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .locked(locked)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: every accepted bit in order; each block is the next 66 bits,
  // after dropping one bit for each slip requested by the lock rules.
  bit rx_q[$];
  bit tx_q[$];
  bit m_locked, m_pend, hold, prev_locked;
  int m_good, m_bad, m_win, consumed, pops, junk, lock_pop, unlock_pop;
  logic [65:0] held;

  task automatic model_pop();
    logic [65:0] exp;
    bit good;
    if (m_pend) begin
      void'(rx_q.pop_front());
      consumed++;
      m_pend = 0;
    end
    check("pop_has_bits", rx_q.size() >= 66, 1);
    if (rx_q.size() < 66) return;
    if (m_locked) check("locked_alignment", 66'((consumed - junk) % 66), 0);
    for (int i = 0; i < 66; i++) exp[i] = rx_q.pop_front();
    consumed += 66;
    pops++;
    check("dout_block", dout, exp);
    good = exp[0] ^ exp[1];
    if (!m_locked) begin
      if (good) begin
        m_good++;
        if (m_good >= 64) begin m_locked = 1; m_bad = 0; m_win = 0; end
      end else begin
        m_good = 0;
        m_pend = 1;
      end
    end else begin
      m_win++;
      if (!good) m_bad++;
      if (m_bad >= 16) begin m_locked = 0; m_good = 0; m_pend = 1; end
      else if (m_win >= 64) begin m_win = 0; m_bad = 0; end
    end
  endtask

  always @(negedge clk) begin
    if (arst) begin
      rx_q.delete();
      m_locked = 0; m_pend = 0; m_good = 0; m_bad = 0; m_win = 0;
      consumed = 0; pops = 0; hold = 0; prev_locked = 0;
      lock_pop = -1; unlock_pop = -1;
    end else begin
      check("locked", locked, m_locked);
      if (locked && !prev_locked && lock_pop < 0) lock_pop = pops;
      if (!locked && prev_locked && unlock_pop < 0) unlock_pop = pops;
      prev_locked = locked;
      if (hold) begin
        check("stall_valid", dout_valid, 1);
        check("stall_dout", dout, held);
      end
      hold = dout_valid && !dout_ready;
      held = dout;
      if (dout_valid && dout_ready) model_pop();
      if (din_valid && din_ready) for (int i = 0; i < 32; i++) rx_q.push_back(din[i]);
      check("fill_le_97", (rx_q.size() - int'(m_pend)) <= 97, 1);
    end
  end

  task automatic add_block(input logic [63:0] pay, input logic [1:0] hdr);
    logic [65:0] b;
    b = {pay, hdr};
    for (int i = 0; i < 66; i++) tx_q.push_back(b[i]);
  endtask

  function automatic logic [1:0] good_hdr();
    return $urandom_range(1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return $urandom_range(1) ? 2'b11 : 2'b00;
  endfunction

  task automatic stream(input int pv, input int pr, input bit strict);
    bit have = 0;
    bit seen = 0;
    int idle = 0;
    int acc = 0;
    logic [31:0] w;
    while (tx_q.size() > 0 || have) begin
      @(posedge clk); #1;
      if (!have && tx_q.size() > 0 && $urandom_range(99) < pv) begin
        w = '0;
        for (int i = 0; i < 32; i++) if (tx_q.size() > 0) w[i] = tx_q.pop_front();
        din = w;
        have = 1;
      end
      din_valid = have;
      dout_ready = $urandom_range(99) < pr;
      @(negedge clk);
      if (strict) begin
        check("din_ready_full_rate", din_ready, 1);
        if (dout_valid && !seen) begin
          seen = 1;
          check("first_valid_after_words", 66'(acc), 3);
          check("first_block", dout, 66'h1);
        end
      end
      if (have && din_ready) begin
        have = 0;
        acc++;
        idle = 0;
      end else if (++idle > 2000) begin
        n_chk++;
        n_fail++;
        $display("FAIL stream_timeout: no din accepted for %0d cycles", idle);
        break;
      end
    end
    @(posedge clk); #1;
    din_valid = 0;
  endtask

  task automatic drain(input int n, input int pr);
    repeat (n) begin
      @(posedge clk); #1;
      din_valid = 0;
      dout_ready = $urandom_range(99) < pr;
    end
    @(posedge clk); #1;
    dout_ready = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    arst = 1;
    din_valid = 0;
    tx_q.delete();
    repeat (2) @(posedge clk);
    #1 arst = 0;
  endtask

  initial begin
    junk = 0;
    arst = 1;
    din_valid = 1;
    din = $urandom;
    dout_ready = 1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("rst_din_ready", din_ready, 0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_locked", locked, 0);
    end
    arst = 0;
    din_valid = 0;
    #1 check("din_ready_after_release", din_ready, 1);

    for (int i = 0; i < 16; i++) add_block({16{4'(i)}}, 2'b01);
    stream(100, 100, 1);
    drain(4, 100);
    check("pack_pops", 66'(pops), 16);

    do_reset();
    for (int i = 0; i < 80; i++) add_block({$urandom, $urandom}, good_hdr());
    stream(100, 100, 0);
    drain(4, 100);
    check("lock_after_pops", 66'(lock_pop), 64);
    check("lock_held", locked, 1);

    do_reset();
    junk = 5;
    for (int i = 0; i < 5; i++) tx_q.push_back(1'($urandom_range(1)));
    for (int i = 0; i < 400; i++) add_block({$urandom, $urandom}, good_hdr());
    stream(100, 100, 0);
    drain(4, 100);
    check("slip_locked", locked, 1);
    check("slip_lock_bound", (lock_pop >= 64) && (lock_pop <= 66 * 64), 1);

    do_reset();
    junk = 0;
    for (int b = 0; b < 280; b++) begin
      automatic int o = (b - 64) % 64;
      automatic bit bad = (b >= 64 && b < 192 && o < 30 && o % 2 == 0) ||
                          (b >= 192 && b < 256 && o < 32 && o % 2 == 0);
      add_block({$urandom, $urandom}, bad ? bad_hdr() : good_hdr());
    end
    stream(100, 100, 0);
    drain(4, 100);
    check("loss_lock_pop", 66'(lock_pop), 64);
    check("loss_unlock_pop", 66'(unlock_pop), 223);
    check("loss_unlocked", locked, 0);

    do_reset();
    for (int i = 0; i < 300; i++) add_block({$urandom, $urandom}, good_hdr());
    stream(70, 50, 0);
    drain(20, 100);
    check("bp_pops", 66'(pops), 300);
    check("bp_locked", locked, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gearbox_32_66.md
# gearbox_32_66

Receive-direction gearbox. It accepts a continuous stream of 32-bit words from the serial side and re-packs it into 66-bit blocks with valid/ready handshakes on both sides. It also acquires 66-bit block alignment by hunting for valid 2-bit sync headers, slipping one bit at a time until it locks. It sits between the transceiver word interface and the 64b/66b descrambler/decoder, mirroring the transmit-side 66→32 gearbox.

## Interface
- LOCK_GOOD, 64: consecutive good headers required to declare lock.
- WINDOW, 64: block window length while locked.
- SLIP_BAD, 16: bad headers within one WINDOW that drop lock.
- clk  in  1  clock; all logic on rising edge.
- arst  in  1  reset, synchronous, active-high.
- din  in  32  serial-side word; bit 0 is earliest on the line.
- din_valid  in  1  din carries data.
- din_ready  out  1  word accepted when din_valid & din_ready.
- dout  out  66  block; bit 0 earliest; sync header is dout[1:0].
- dout_valid  out  1  dout holds a complete block.
- dout_ready  in  1  block taken when dout_valid & dout_ready.
- locked  out  1  block alignment acquired.

## Operation
- **Bit buffer:** 97-bit shift buffer `buf` with a 7-bit `fill` (0..97). Oldest bit is at buf[0].
- **Push:** an accepted din is written to buf[fill+31:fill] (position adjusted for a same-cycle pop or slip); fill += 32.
- **Pop:** dout = buf[65:0] and is registered. On pop, buf shifts right 66 and fill -= 66.
- **dout_valid** = (fill ≥ 66) & !slip_pending.
- **din_ready** = !arst & ((fill < 66) | (dout_valid & dout_ready)). Push and pop in the same cycle give fill' = fill − 66 + 32. fill never exceeds 97.
- **Header check** on each pop: good if dout[1:0] is 01 or 10; bad if 00 or 11.
- **State UNLOCKED:**
  - Good header: good_cnt++. When good_cnt reaches LOCK_GOOD → LOCKED, and bad_cnt and win_cnt clear.
  - Bad header: good_cnt = 0 and slip_pending = 1.
- **State LOCKED:**
  - Every pop: win_cnt++. A bad header also does bad_cnt++.
  - bad_cnt reaching SLIP_BAD → UNLOCKED, good_cnt = 0, slip_pending = 1.
  - Otherwise, when win_cnt reaches WINDOW, win_cnt and bad_cnt clear.
  - Bad-count check takes priority over the window-end clear in the same cycle.
- **Slip:**
  - While slip_pending = 1 and fill ≥ 1, buf shifts right 1 and fill -= 1, then slip_pending clears.
  - A push in the same cycle lands at fill − 1.
  - No pop can occur while slip_pending is set.
- **Output:** locked = (state == LOCKED). Blocks are delivered whether or not locked; the consumer qualifies them with locked.
- **Counters:** good_cnt, bad_cnt and win_cnt are wide enough for their parameter values and saturate; none wraps.

## Timing
- **Reset:** while arst is high, and on the first edge after it, all of the following hold:
  - fill = 0, buf = 0, dout = 0, dout_valid = 0, din_ready = 0, locked = 0.
  - state = UNLOCKED, all counters = 0, slip_pending = 0.
- **Reset mid-operation:** arst discards all buffered bits and drops lock on the next edge.
- **First block:** dout_valid rises in the cycle after the 3rd accepted din (fill 96 ≥ 66).
- **Throughput:** sustains one din per cycle with dout_ready held high. Steady state averages 33 din words per 16 blocks with no din stall.
- **Downstream stall:** with dout_ready low, fill fills to at most 97. din_ready then stays 0 while fill ≥ 66. dout stays stable until popped.
- **Lock decision:** the state change takes effect on the edge after the pop that triggers it.
- **Slip effect:** a slip costs at most one cycle of dout_valid = 0, beyond any wait for fill to reach 66 again.
- **locked transitions** are registered, so there is no combinational path from dout to locked.

## Test plan
- **Reset behaviour:** assert arst for 3 cycles with din_valid = 1 → din_ready = 0, dout_valid = 0 and locked = 0 throughout. din_ready = 1 on the first cycle after release.
- **Packing:** serialize blocks B0..B15 LSB-first (each header 01, payload = index pattern) as 33 din words at full rate, dout_ready = 1 → dout equals B0..B15 in order. No din_ready deassertion occurs. First dout_valid follows the 3rd accepted word.
- **Lock acquisition:** stream aligned good blocks → locked rises after exactly LOCK_GOOD = 64 pops and stays high.
- **Slip hunt:** prefix the stream with 5 junk bits → each bad header in UNLOCKED causes one slip. Lock is achieved within 66 × 64 blocks, and output blocks then match the transmitted payload.
- **Loss of lock:** once locked, corrupt 16 headers within one 64-block window → locked falls one cycle after the 16th bad pop. Corrupting 15 per window keeps locked high indefinitely.
- **Backpressure:** random dout_ready (50%) and din_valid (70%) → no block is lost or duplicated, fill stays ≤ 97, and dout holds stable while dout_valid & !dout_ready.
